// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: access sizes, FSM states and the
// IO-region address test.
package mem_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IF_RD = 2'd1,
      LS_RD = 2'd2,
      LS_WR = 2'd3
   } state_t;

   // UART and other memory-mapped IO live where addr[17:16] == 2'b11.
   function automatic logic is_io_addr(input logic [31:0] addr);
      return addr[17:16] == 2'b11;
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto a byte-wide RAM port,
// serialising words into byte beats with round-robin tie-breaking.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ready,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   state_t      state_q, state_d;
   logic        last_ls_q, last_ls_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] asm_q, asm_d;
   logic        held_q, held_d;
   logic        if_ready_q, if_ready_d;
   logic        ls_ready_q, ls_ready_d;

   logic        reading;
   logic        capture;
   logic        io_hold;
   logic        grant_ls;
   logic [1:0]  slot;
   logic [2:0]  rd_off;

   assign reading = (state_q == IF_RD) || (state_q == LS_RD);
   assign capture = reading && (cnt_q != 3'd0) && !held_q;
   assign slot    = cnt_q[1:0] - 2'd1;
   assign io_hold = is_io_addr(base_q) && io_buffer_full;
   // Final read cycle keeps the last address so no extra location is touched.
   assign rd_off  = (cnt_q < len_q) ? cnt_q : len_q - 3'd1;

   always_comb begin
      state_d    = state_q;
      last_ls_d  = last_ls_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      asm_d      = asm_q;
      held_d     = held_q;
      grant_ls   = 1'b0;
      if_ready_d = rdy_in ? 1'b0 : if_ready_q;
      ls_ready_d = rdy_in ? 1'b0 : ls_ready_q;

      // Byte c-1 sits on mem_din for only one edge after its address; take it
      // even when paused and remember that it is already in hand.
      if (capture)
         asm_d[{slot, 3'b000} +: 8] = mem_din;

      if (!rdy_in) begin
         held_d = held_q | capture;
      end else begin
         case (state_q)
            IDLE: begin
               if (!if_ready_q && !ls_ready_q && !flush_in && (if_req || ls_req)) begin
                  grant_ls  = ls_req && (!if_req || !last_ls_q);
                  last_ls_d = grant_ls;
                  cnt_d     = 3'd0;
                  held_d    = 1'b0;
                  asm_d     = '0;
                  if (grant_ls) begin
                     base_d  = ls_addr;
                     len_d   = size_bytes(ls_size);
                     wdata_d = ls_wdata;
                     state_d = ls_wr ? LS_WR : LS_RD;
                  end else begin
                     base_d  = if_addr;
                     len_d   = 3'd4;
                     state_d = IF_RD;
                  end
               end
            end
            IF_RD, LS_RD: begin
               held_d = 1'b0;
               cnt_d  = cnt_q + 3'd1;
               if (flush_in) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else if (cnt_q == len_q) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
                  if (state_q == IF_RD)
                     if_ready_d = 1'b1;
                  else
                     ls_ready_d = 1'b1;
               end
            end
            LS_WR: begin
               if (!io_hold) begin
                  if (cnt_q == len_q - 3'd1) begin
                     state_d    = IDLE;
                     cnt_d      = 3'd0;
                     ls_ready_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      mem_a    = '0;
      mem_dout = '0;
      mem_wr   = 1'b0;
      case (state_q)
         IF_RD, LS_RD: mem_a = base_q + {29'd0, rd_off};
         LS_WR: begin
            mem_a    = base_q + {29'd0, cnt_q};
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in && !io_hold;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         last_ls_q  <= 1'b0;
         cnt_q      <= '0;
         len_q      <= '0;
         base_q     <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         held_q     <= 1'b0;
         if_ready_q <= 1'b0;
         ls_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ls_q  <= last_ls_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         asm_q      <= asm_d;
         held_q     <= held_d;
         if_ready_q <= if_ready_d;
         ls_ready_q <= ls_ready_d;
      end
   end

   assign if_ready = if_ready_q;
   assign if_data  = asm_q;
   assign ls_ready = ls_ready_q;
   assign ls_rdata = asm_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst_in  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: rdy_in  in  1  low = pause; all state frozen.
REQ-004 SHALL have ports: flush_in  in  1  misprediction clear.
REQ-005 SHALL have ports: if_req  in  1  fetch request; if_addr  in  32  fetch byte address.
REQ-006 SHALL have ports: if_ready  out  1  one-cycle fetch-done pulse; if_data  out  32  fetched word, little-endian.
REQ-007 SHALL have ports: ls_req  in  1  load/store request; ls_wr  in  1  1 = store; ls_size  in  2  00 byte, 01 half, 10 word (N = 1/2/4).
REQ-008 SHALL have ports: ls_addr  in  32  access address; ls_wdata  in  32  store data, low N bytes used.
REQ-009 SHALL have ports: ls_ready  out  1  one-cycle done pulse; ls_rdata  out  32  load bytes zero-extended.
REQ-010 SHALL have ports: mem_din  in  8  RAM read data, valid one cycle after address; mem_dout  out  8  write byte.
REQ-011 SHALL have ports: mem_a  out  32  byte address; mem_wr  out  1  1 = write; io_buffer_full  in  1  UART full.

Function
REQ-012 SHALL implement FSM states IDLE, IF_RD, LS_RD, LS_WR.
REQ-013 SHALL, in IDLE, accept a request only when that requester's req is high at a rising edge.
REQ-014 SHALL latch address, size, write data and direction at the accepting edge.
REQ-015 SHALL, when if_req and ls_req are both high in IDLE, grant round-robin: opposite of last grant; last grant resets to IF, so LS wins first tie.
REQ-016 SHALL make reads N+1 busy cycles c=0..N (fetch N=4): mem_a = base+c for c<N, mem_wr=0; byte c-1 captured from mem_din in cycle c.
REQ-017 SHALL raise ready with data N+1 edges after the acceptance edge, for one cycle, returning to IDLE.
REQ-018 SHALL make writes N cycles c=0..N-1: mem_a = base+c, mem_dout = byte c, mem_wr=1; ls_ready pulses N edges after acceptance.
REQ-019 SHALL not accept a new request in the cycle its own ready pulse is high; minimum one-cycle gap.
REQ-020 SHALL, for a write with base[17:16]==2'b11 while io_buffer_full=1, hold the current byte with mem_wr=0 until io_buffer_full=0, then issue it.
REQ-021 SHALL treat unaligned addresses as legal; increment address modulo 2^32.
REQ-022 SHALL, on flush_in=1 in IF_RD or LS_RD, go to IDLE at that edge with no ready pulse; requests in the flush cycle are ignored.
REQ-023 SHALL NOT abort LS_WR on flush_in; stores are commit-time and complete.
REQ-024 SHALL, on rdy_in=0, freeze state, counters and outputs except mem_wr, which is forced 0; resume with the same mem_a so the read byte stays valid.
REQ-025 SHALL drive mem_a=0, mem_dout=0, mem_wr=0 in IDLE.
REQ-026 SHALL keep if_data and ls_rdata valid only during the ready pulse; otherwise don't-care.

Reset
REQ-027 SHALL, on rst_in, immediately force: state IDLE, last grant IF, all counters 0.
REQ-028 SHALL, on rst_in, immediately force outputs 0: if_ready, if_data, ls_ready, ls_rdata, mem_a, mem_dout, mem_wr.
REQ-029 SHALL, on reset mid-operation, drop the access with no ready pulse; a partial store remains partial.

Structure
REQ-030 SHALL place the following in the shared constants package: ls_size encodings, FSM state encodings, and the IO-region test (addr[17:16]==2'b11).
REQ-031 SHALL be a single module with no sub-module.
REQ-032 SHALL keep byte assembly and the round-robin flag inline.

Verification
REQ-033 SHALL verify fetch: if_req, if_addr=0x100, RAM bytes 13,00,00,00 -> mem_a 0x100..0x103 on cycles 1-4; if_ready after edge 5, if_data=0x00000013.
REQ-034 SHALL verify tie: if_req and ls_req (load word at 0x200) same edge after reset -> LS served first; IF accepted after LS pulse plus one-cycle gap.
REQ-035 SHALL verify store byte: ls_wr, size 00, addr 0x30000, data 0x41, io_buffer_full=1 for 3 cycles -> mem_wr=0 for 3 cycles, then one cycle mem_a=0x30000, mem_dout=0x41, mem_wr=1, then ls_ready.
REQ-036 SHALL verify flush: flush_in in cycle 2 of a fetch -> IDLE next edge, no if_ready; flush during a word store -> all 4 bytes written, ls_ready pulses.
REQ-037 SHALL verify pause: rdy_in low 2 cycles mid-load of half at 0x1FFFF -> mem_a held, mem_wr=0; ls_rdata correct with bytes at 0x1FFFF and 0x20000.
REQ-038 SHALL verify reset: rst_in asserted mid-load -> all outputs 0 immediately, no ls_ready.
